// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the ALU round-robin scheduler
package alu_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;
  localparam logic [1:0] INP_BOTH    = 2'b11;
  localparam logic [1:0] INP_NONE    = 2'b00;
  localparam int         CNT_W       = 8;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } alu_flags_t;

  // Only the two arithmetic-mode multiplies take the long ALU path.
  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL);
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - combinational round-robin pick starting at ptr
module alu_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [ID_W-1:0] j;

  // Scan from the farthest offset down so the nearest set bit after ptr is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      j = ID_W'((int'(ptr) + off) % N);
      if (req[j]) begin
        any      = 1'b1;
        idx      = j;
        grant    = '0;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - shares one ALU among NUM_REQ requesters, one operation in flight
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LAT        = 1,
  parameter int MUL_LAT    = 2,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ*4-1:0]         req_cmd,
  input  logic [NUM_REQ-1:0]           req_cin,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opa,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_WIDTH+1:0]        rsp_res,
  output logic [5:0]                   rsp_flags,
  output logic                         alu_ce,
  output logic                         alu_mode,
  output logic                         alu_cin,
  output logic [3:0]                   alu_cmd,
  output logic [1:0]                   alu_inp_valid,
  output logic [DATA_WIDTH-1:0]        alu_opa,
  output logic [DATA_WIDTH-1:0]        alu_opb,
  input  logic [DATA_WIDTH+1:0]        alu_res,
  input  logic                         alu_err,
  input  logic                         alu_oflow,
  input  logic                         alu_cout,
  input  logic                         alu_g,
  input  logic                         alu_l,
  input  logic                         alu_e
);

  localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);

  sched_state_t          state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       cur_id;
  logic [ID_W-1:0]       next_ptr;
  logic [CNT_W-1:0]      lat_cnt;
  logic [NUM_REQ-1:0]    pick_grant;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_any;
  alu_flags_t            alu_flags;

  logic                  sel_mode;
  logic                  sel_cin;
  logic [3:0]            sel_cmd;
  logic [DATA_WIDTH-1:0] sel_opa;
  logic [DATA_WIDTH-1:0] sel_opb;

  alu_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is visible only while idle and out of reset, so it never overlaps a response.
  assign req_ready = (state == IDLE && rst) ? pick_grant : '0;

  assign alu_flags = '{err: alu_err, oflow: alu_oflow, cout: alu_cout,
                       g: alu_g, l: alu_l, e: alu_e};

  assign next_ptr = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;

  always_comb begin
    sel_mode = 1'b0;
    sel_cin  = 1'b0;
    sel_cmd  = '0;
    sel_opa  = '0;
    sel_opb  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_mode = req_mode[i];
        sel_cin  = req_cin[i];
        sel_cmd  = req_cmd[i*4 +: 4];
        sel_opa  = req_opa[i*DATA_WIDTH +: DATA_WIDTH];
        sel_opb  = req_opb[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur_id        <= '0;
      lat_cnt       <= '0;
      alu_ce        <= 1'b0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      alu_cmd       <= '0;
      alu_inp_valid <= INP_NONE;
      alu_opa       <= '0;
      alu_opb       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            cur_id        <= pick_idx;
            alu_ce        <= 1'b1;
            alu_mode      <= sel_mode;
            alu_cin       <= sel_cin;
            alu_cmd       <= sel_cmd;
            alu_opa       <= sel_opa;
            alu_opb       <= sel_opb;
            alu_inp_valid <= INP_BOTH;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= is_mul(alu_mode, alu_cmd) ? MUL_LAT_C : LAT_C;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == CNT_W'(1)) begin
            rsp_valid     <= 1'b1;
            rsp_id        <= cur_id;
            rsp_res       <= alu_res;
            rsp_flags     <= alu_flags;
            alu_ce        <= 1'b0;
            alu_mode      <= 1'b0;
            alu_cin       <= 1'b0;
            alu_cmd       <= '0;
            alu_opa       <= '0;
            alu_opb       <= '0;
            alu_inp_valid <= INP_NONE;
            state         <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          // Fairness advances on completion, not on grant.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - scoreboard bench for alu_rr_scheduler with a behavioural ALU
module tb_alu_rr_scheduler;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int LAT     = 1;
  localparam int MUL_LAT = 2;
  localparam int IDW     = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_mode, req_cin;
  logic [N*4-1:0]  req_cmd;
  logic [N*DW-1:0] req_opa, req_opb;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [DW+1:0]   rsp_res;
  logic [5:0]      rsp_flags;
  logic            alu_ce, alu_mode, alu_cin;
  logic [3:0]      alu_cmd;
  logic [1:0]      alu_inp_valid;
  logic [DW-1:0]   alu_opa, alu_opb;
  logic [DW+1:0]   alu_res;
  logic            alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .LAT(LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_cin(req_cin), .req_opa(req_opa), .req_opb(req_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
    .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow),
    .alu_cout(alu_cout), .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e)
  );

  // Returns {err,oflow,cout,g,l,e,res}.
  function automatic logic [DW+7:0] alu_fn(input logic mode, input logic [3:0] cmd,
                                           input logic cin, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW+1:0] ax, bx, r;
    logic err;
    ax  = {2'b00, a};
    bx  = {2'b00, b};
    r   = '0;
    err = 1'b0;
    if (mode) begin
      case (cmd)
        4'd0:    r = ax + bx;
        4'd1:    r = ax - bx;
        4'd2:    r = ax + bx + {{(DW+1){1'b0}}, cin};
        4'd9:    r = (ax + 1) * (bx + 1);
        4'd10:   r = (ax << 1) * bx;
        default: begin r = {2'b00, a ^ b}; err = (cmd > 4'd10); end
      endcase
    end else begin
      case (cmd)
        4'd0:    r = {2'b00, a & b};
        4'd1:    r = {2'b00, a | b};
        4'd2:    r = {2'b00, a ^ b};
        4'd12:   begin r = {2'b00, a[DW-2:0], a[DW-1]}; err = |b[DW-1:4]; end
        4'd13:   begin r = {2'b00, a[0], a[DW-1:1]};    err = |b[DW-1:4]; end
        default: begin r = {2'b00, ~a}; err = (cmd > 4'd13); end
      endcase
    end
    return {err, r[DW+1], r[DW], a > b, a < b, a == b, r};
  endfunction

  function automatic int lat_of(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? MUL_LAT : LAT;
  endfunction

  function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] s;
    for (int off = 0; off < N; off++) begin
      s = v >> ((ptr + off) % N);
      if (s[0]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  // Behavioural ALU: drives corrupted outputs until the operation has been held for its latency.
  int alu_cnt;
  logic [DW+7:0] alu_out;
  always @(posedge clk or negedge rst)
    if (!rst) alu_cnt <= 0;
    else      alu_cnt <= alu_ce ? alu_cnt + 1 : 0;
  always_comb begin
    alu_out = alu_fn(alu_mode, alu_cmd, alu_cin, alu_opa, alu_opb);
    if (alu_cnt < lat_of(alu_mode, alu_cmd) || alu_inp_valid != 2'b11)
      alu_out = alu_out ^ {6'h2A, 10'h155};
  end
  assign {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_res} = alu_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [IDW+DW+7:0] exp_q[$];
  bit            m_busy = 0;
  int            m_acc, m_lat, m_id, m_ptr = 0, cycle = 0;
  logic          m_mode, m_cin;
  logic [3:0]    m_cmd;
  logic [DW-1:0] m_opa, m_opb;
  logic [N-1:0]  last_ready;
  logic [N-1:0]  grant_log[$];

  task automatic model_reset();
    m_busy = 0;
    m_ptr  = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    logic [N-1:0] exp_ready, grant_mask;
    logic [IDW-1:0] wi;
    bit rsp_due, ce_due;
    int w;
    @(negedge clk);
    exp_ready = '0;
    w = -1;
    if (rst && !m_busy) begin
      w = rr_winner(req_valid, m_ptr);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    rsp_due = m_busy && (cycle >= m_acc + m_lat + 2);
    ce_due  = m_busy && (cycle >= m_acc + 1) && (cycle <= m_acc + 1 + m_lat);
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, rsp_due);
    check("alu_ce", alu_ce, ce_due);
    check("alu_inp_valid", alu_inp_valid, ce_due ? 2'b11 : 2'b00);
    check("alu_operands", {alu_mode, alu_cin, alu_cmd, alu_opa, alu_opb},
          ce_due ? {m_mode, m_cin, m_cmd, m_opa, m_opb} : 22'h0);
    last_ready = req_ready;
    if (req_ready != '0) grant_log.push_back(req_ready);
    grant_mask = '0;
    if (w >= 0) begin
      wi     = w[IDW-1:0];
      m_busy = 1;
      m_acc  = cycle;
      m_id   = w;
      m_mode = req_mode[wi];
      m_cin  = req_cin[wi];
      m_cmd  = req_cmd[w*4 +: 4];
      m_opa  = req_opa[w*DW +: DW];
      m_opb  = req_opb[w*DW +: DW];
      m_lat  = lat_of(m_mode, m_cmd);
      exp_q.push_back({wi, alu_fn(m_mode, m_cmd, m_cin, m_opa, m_opb)});
      grant_mask[wi] = 1'b1;
    end else if (rsp_due && rsp_ready) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % N;
    end
    cycle++;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~grant_mask;
  endtask

  task automatic raise(input int i, input logic mode, input logic [3:0] cmd, input logic cin,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [IDW-1:0] ii;
    ii = i[IDW-1:0];
    req_mode[ii]        = mode;
    req_cin[ii]         = cin;
    req_cmd[i*4 +: 4]   = cmd;
    req_opa[i*DW +: DW] = a;
    req_opb[i*DW +: DW] = b;
    req_valid[ii]       = 1'b1;
  endtask

  task automatic raise_rand(input int i);
    logic [3:0] cmd;
    cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 10)) : 4'($urandom_range(0, 15));
    raise(i, 1'($urandom), cmd, 1'($urandom), DW'($urandom), DW'($urandom));
  endtask

  task automatic drain();
    int t;
    t = 0;
    rsp_ready = 1'b1;
    while ((req_valid != '0 || m_busy) && t < 200) begin
      tick();
      t++;
    end
    compared++;
    if (req_valid != '0 || m_busy) begin
      mismatched++;
      $display("FAIL drain_timeout: pending=%b busy=%0d required idle", req_valid, m_busy);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_fields"}, {rsp_id, rsp_res, rsp_flags}, 0);
    check({tag, "_alu_ctl"}, {alu_ce, alu_inp_valid, alu_mode, alu_cin, alu_cmd}, 0);
    check({tag, "_alu_ops"}, {alu_opa, alu_opb}, 0);
  endtask

  // Monitor: pops the scoreboard on the first cycle of each response, then checks it holds.
  bit            in_rsp = 0;
  logic [IDW+DW+7:0] held;
  logic [IDW-1:0] last_id;
  logic [DW+1:0]  last_res;
  logic [5:0]     last_flags;
  always @(negedge clk) begin
    logic [IDW+DW+7:0] e;
    if (!rst) begin
      in_rsp = 0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rsp_unexpected: got id=%0d res=%0h with empty scoreboard", rsp_id, rsp_res);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e[DW+8 +: IDW]);
          check("rsp_res", rsp_res, e[DW+1:0]);
          check("rsp_flags", rsp_flags, e[DW+2 +: 6]);
        end
        in_rsp     = 1;
        held       = {rsp_id, rsp_flags, rsp_res};
        last_id    = rsp_id;
        last_res   = rsp_res;
        last_flags = rsp_flags;
      end else begin
        check("rsp_hold", {rsp_id, rsp_flags, rsp_res}, held);
      end
      if (rsp_ready) in_rsp = 0;
    end
  end

  initial begin
    int t;
    req_valid = '0; req_mode = '0; req_cin = '0; req_cmd = '0; req_opa = '0; req_opb = '0;
    rsp_ready = 1'b1;

    // Reset with every requester already asserting.
    for (int i = 0; i < N; i++) raise_rand(i);
    #3;
    check_zero("reset");
    tick();
    tick();
    rst = 1'b1;

    grant_log.delete();
    t = 0;
    while (grant_log.size() < 5 && t < 60) begin
      tick();
      for (int i = 0; i < N; i++) if (!req_valid[i]) raise_rand(i);
      t++;
    end
    check("rr_order_len", grant_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check($sformatf("rr_order_%0d", k), grant_log[k], 4'b0001 << (k % N));
    drain();

    raise(2, 1'b1, 4'd0, 1'b0, 8'h0F, 8'h01);
    drain();
    check("single_id", last_id, 2);
    check("single_res", last_res, 10'h010);

    raise(0, 1'b1, 4'd9, 1'b0, 8'h03, 8'h04);
    drain();
    check("mul_id", last_id, 0);
    check("mul_res", last_res, 10'h014);

    // Backpressure: response held off while requester 1 waits.
    rsp_ready = 1'b0;
    raise(0, 1'b1, 4'd1, 1'b0, 8'h40, 8'h11);
    t = 0;
    while (!(m_busy && cycle > m_acc + m_lat + 2) && t < 20) begin tick(); t++; end
    raise(1, 1'b1, 4'd2, 1'b1, 8'h7F, 8'h01);
    repeat (5) tick();
    rsp_ready = 1'b1;
    tick();
    tick();
    check("bp_grant_after_hs", last_ready, 4'b0010);
    drain();

    // Leave the pointer at 3, then reset in the middle of a multiply's WAIT.
    raise(2, 1'b0, 4'd1, 1'b0, 8'h12, 8'h34);
    drain();
    raise(3, 1'b1, 4'd10, 1'b0, 8'h05, 8'h06);
    t = 0;
    while (!m_busy && t < 20) begin tick(); t++; end
    tick();
    rst = 1'b0;
    raise(1, 1'b1, 4'd0, 1'b0, 8'h01, 8'h02);
    raise(3, 1'b1, 4'd0, 1'b0, 8'h03, 8'h04);
    model_reset();
    #1;
    check_zero("rst_wait");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_first_grant", last_ready, 4'b0010);
    drain();

    raise(1, 1'b0, 4'd12, 1'b0, 8'hA5, 8'h10);
    drain();
    check("err_flag", last_flags[5], 1'b1);
    check("err_id", last_id, 1);
    raise(3, 1'b1, 4'd0, 1'b0, 8'h22, 8'h11);
    drain();
    check("after_err_id", last_id, 3);

    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) raise_rand(i);
      tick();
    end
    drain();
    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
